jtbubl_rom_arb: RTL and testbench
=================================

// Module: jtbubl_rom_arb
// PURPOSE
//  Arbitrates SDRAM ROM reads for the five Bubble Bobble fetch slots: main, sub, MCU, sound, GFX.
//  Sits between the game-level slot requesters and the SDRAM controller, downstream of the game top.
//  Each slot has a one-word (32-bit) cache with an address tag.
//  Misses are served round-robin over a single req/ack/data_rdy handshake.
// PARAMETERS
//  OFF0  22'h00000  word offset added to slot 0 (main) address
//  OFF1  22'h14000  word offset, slot 1 (sub)
//  OFF2  22'h1C000  word offset, slot 2 (MCU)
//  OFF3  22'h18000  word offset, slot 3 (sound)
//  OFF4  22'h20000  word offset, slot 4 (GFX)
// PORTS
//  clk          in   1    system clock (SDRAM domain)
//  rstn         in   1    asynchronous, active-low reset
//  downloading  in   1    ROM download in progress; blocks all fetches
//  loop_rst     in   1    flush request; invalidates all caches
//  slot_cs      in   5    per-slot read request, bit i = slot i
//  slot_addr    in   110  packed 5x22 word addresses, slot i at [22*i+:22], before offset
//  slot_ok      out  5    slot i cache holds data for its current address
//  slot_dout    out  160  packed 5x32 cached words, slot i at [32*i+:32]
//  sdram_req    out  1    read request to SDRAM controller
//  sdram_addr   out  22   word address of the pending request (offset included)
//  sdram_ack    in   1    controller accepted the request
//  data_rdy     in   1    data_read valid this cycle
//  data_read    in   32   SDRAM read data
//  refresh_en   out  1    bus idle; controller may refresh
// BEHAVIOUR
//  Reset: all outputs 0; all valid bits 0; tags 0; FSM=IDLE; rr pointer=0.
//  full_i = slot_addr_i + OFF_i, computed in 22 bits; wrap-around modulo 2^22 is accepted.
//  slot_ok_i = slot_cs_i & valid_i & (tag_i == full_i). This is combinational from registers.
//  miss_i = slot_cs_i & ~slot_ok_i & ~downloading.
//  FSM IDLE:
//   - If any miss: grant the first missing slot scanning upward from rr pointer, wrapping 4->0.
//   - Latch sel, and latch sdram_addr = full_sel.
//   - Set sdram_req=1 and go to WAIT_ACK. Exactly one cycle IDLE->req.
//  FSM WAIT_ACK:
//   - Hold sdram_req and sdram_addr.
//   - On sdram_ack: clear sdram_req and go to WAIT_DATA.
//   - If data_rdy is asserted in the same cycle: capture immediately and go to IDLE.
//  FSM WAIT_DATA:
//   - On data_rdy: dout_sel <= data_read, tag_sel <= latched address, valid_sel <= 1.
//   - rr pointer <= sel+1 (mod 5). Go to IDLE.
//   - slot_ok_sel rises the cycle after data_rdy, provided the address is unchanged.
//  Address change or cs drop mid-fetch:
//   - The fetch completes and the tag holds the requested address.
//   - slot_ok stays 0 for the new address.
//   - A new miss is served next in round-robin order. No abort is issued to SDRAM.
//  downloading=1 or loop_rst=1:
//   - Clear all valid bits. Once any outstanding SDRAM transaction completes, go to IDLE.
//   - Data from that transaction is discarded, not cached. No new requests are issued.
//  Only one SDRAM transaction is outstanding at a time.
//  If all slots miss continuously, each slot is served at least once every 5 fetches.
//  refresh_en = (state==IDLE) & ~|miss. It is registered, so it lags by one cycle.
//  A write to a slot's cache leaves the other slots' caches untouched.
//  Reset asserted mid-transaction: all state clears asynchronously.
// STRUCTURE
//  Package jtbubl_rom_pkg holds:
//   - NSLOT=5, AW=22, DW=32
//   - state localparams IDLE/WAIT_ACK/WAIT_DATA
//   - default offset constants
//  Sub-module jtbubl_rom_rr is the 5-way round-robin picker.
//   - Inputs: miss[4:0], ptr.
//   - Outputs: gnt_idx[2:0], any.
//   - Purely combinational.
//  The top holds the tag/valid/data register file and the FSM.
// TESTING
//  Slot0 cs, addr=0x00010, idle bus:
//   - sdram_req=1 the next cycle with sdram_addr=0x00010.
//   - Ack at +2, data_rdy with 0xDEADBEEF at +4.
//   - slot_ok[0]=1 and slot_dout[31:0]=0xDEADBEEF at +5.
//  Slot1 cs, addr=0x00020:
//   - sdram_addr=0x14020.
//   - After fill, toggle addr to 0x00021: slot_ok[1] drops in the same cycle and a new request issues.
//  Slots 0-4 all miss at once:
//   - Grant order is 0,1,2,3,4.
//   - Then slot 0 misses again after slot 2 was served: next grant is 3 before 0.
//  During WAIT_DATA, change slot4 addr:
//   - The line fills with the old tag.
//   - slot_ok[4] stays 0, followed by a refetch at the new address.
//  Assert downloading while in WAIT_ACK with a filled slot0:
//   - The transaction completes. slot_ok=0 everywhere and no further sdram_req.
//   - refresh_en=1 once the FSM is IDLE.
//  ack and data_rdy on the same cycle: fill happens in that cycle; FSM returns to IDLE.
//  Deassert rstn mid-WAIT_DATA: all outputs 0 immediately (asynchronous reset).

Source files
------------

// File: rtl/jtbubl_rom_pkg.sv
// Shared sizes, FSM encodings and default slot offsets for the Bubble Bobble ROM arbiter.
package jtbubl_rom_pkg;
  localparam int NSLOT = 5;
  localparam int AW    = 22;
  localparam int DW    = 32;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  localparam logic [AW-1:0] OFF0_DEF = 22'h00000;
  localparam logic [AW-1:0] OFF1_DEF = 22'h14000;
  localparam logic [AW-1:0] OFF2_DEF = 22'h1C000;
  localparam logic [AW-1:0] OFF3_DEF = 22'h18000;
  localparam logic [AW-1:0] OFF4_DEF = 22'h20000;

  function automatic logic [2:0] rr_next(input logic [2:0] s);
    return (s == 3'(NSLOT-1)) ? 3'd0 : s + 3'd1;
  endfunction
endpackage

// File: rtl/jtbubl_rom_rr.sv
// Five-way round-robin picker: first set miss bit at or after ptr, wrapping 4->0.
module jtbubl_rom_rr
  import jtbubl_rom_pkg::*;
(
  input  logic [NSLOT-1:0] miss,
  input  logic [2:0]       ptr,
  output logic [2:0]       gnt_idx,
  output logic             any
);
  logic [3:0] idx;
  logic       found;

  always_comb begin
    gnt_idx = 3'd0;
    found   = 1'b0;
    idx     = 4'd0;
    for (int i = 0; i < NSLOT; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(NSLOT)) idx = idx - 4'(NSLOT);
      if (!found && miss[idx[2:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[2:0];
      end
    end
  end

  assign any = |miss;
endmodule

// File: rtl/jtbubl_rom_arb.sv
// Per-slot one-word ROM caches with round-robin miss service over one SDRAM req/ack/data_rdy port.
module jtbubl_rom_arb
  import jtbubl_rom_pkg::*;
#(
  parameter logic [AW-1:0] OFF0 = OFF0_DEF,
  parameter logic [AW-1:0] OFF1 = OFF1_DEF,
  parameter logic [AW-1:0] OFF2 = OFF2_DEF,
  parameter logic [AW-1:0] OFF3 = OFF3_DEF,
  parameter logic [AW-1:0] OFF4 = OFF4_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [NSLOT-1:0]    slot_cs,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT-1:0]    slot_ok,
  output logic [NSLOT*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);
  logic [NSLOT-1:0][AW-1:0] offs, full, tag;
  logic [NSLOT-1:0][DW-1:0] dout;
  logic [NSLOT-1:0]         valid, miss;
  logic [1:0]               state, nxt;
  logic [2:0]               sel, ptr, gnt;
  logic                     any, done, disc, fill, flush;

  assign offs  = {OFF4, OFF3, OFF2, OFF1, OFF0};
  assign flush = downloading | loop_rst;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign full[i]              = slot_addr[i*AW +: AW] + offs[i];
    assign slot_ok[i]           = slot_cs[i] & valid[i] & (tag[i] == full[i]);
    assign miss[i]              = slot_cs[i] & ~slot_ok[i] & ~downloading;
    assign slot_dout[i*DW +: DW] = dout[i];
  end

  jtbubl_rom_rr u_rr (
    .miss    (miss),
    .ptr     (ptr),
    .gnt_idx (gnt),
    .any     (any)
  );

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= nxt;

  // loop_rst only blocks new grants; downloading is already folded into miss
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (any && !loop_rst) nxt = WAIT_ACK;
      WAIT_ACK:  if (sdram_ack) nxt = data_rdy ? IDLE : WAIT_DATA;
      WAIT_DATA: if (data_rdy) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = 1'b0;
    done      = 1'b0;
    case (state)
      WAIT_ACK: begin
        sdram_req = 1'b1;
        done      = sdram_ack & data_rdy;
      end
      WAIT_DATA: done = data_rdy;
      default: ;
    endcase
  end

  // A flush seen while a transaction is in flight poisons its data
  assign fill = done & ~disc & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel        <= 3'd0;
      ptr        <= 3'd0;
      sdram_addr <= '0;
      disc       <= 1'b0;
      refresh_en <= 1'b0;
    end else begin
      if (state == IDLE && nxt == WAIT_ACK) begin
        sel        <= gnt;
        sdram_addr <= full[gnt];
      end
      if (done) ptr <= rr_next(sel);
      if (done)                         disc <= 1'b0;
      else if (flush && state != IDLE)  disc <= 1'b1;
      refresh_en <= (state == IDLE) & ~any;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      tag   <= '0;
      dout  <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[sel] <= 1'b1;
      tag[sel]   <= sdram_addr;
      dout[sel]  <= data_read;
    end
  end
endmodule

// File: tb/tb_jtbubl_rom_arb.sv
// Directed bench: SDRAM request addresses are scoreboarded by a monitor; cache state checked inline.
module tb_jtbubl_rom_arb;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         downloading = 1'b0, loop_rst = 1'b0;
  logic [4:0]   slot_cs = '0;
  logic [109:0] slot_addr = '0;
  logic [4:0]   slot_ok;
  logic [159:0] slot_dout;
  logic         sdram_req;
  logic [21:0]  sdram_addr;
  logic         sdram_ack = 1'b0, data_rdy = 1'b0;
  logic [31:0]  data_read = '0;
  logic         refresh_en;

  int pass_c = 0, total_c = 0;
  int mon_pass = 0, mon_total = 0;
  logic [21:0] exp_q[$];
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  jtbubl_rom_arb dut (
    .clk(clk), .rstn(rstn), .downloading(downloading), .loop_rst(loop_rst),
    .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
  );

  // Monitor: every new request must match the next expected address
  always @(negedge clk) begin
    if (rstn && sdram_req && !req_q) begin
      mon_total++;
      if (exp_q.size() == 0)
        $display("FAIL req_addr: unexpected request got=%h", sdram_addr);
      else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if (sdram_addr === e) mon_pass++;
        else $display("FAIL req_addr: got=%h want=%h", sdram_addr, e);
      end
    end
    req_q = sdram_req;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_c++;
    if (act === exp) pass_c++;
    else $display("FAIL %s: got=%h want=%h", name, act, exp);
  endtask

  task automatic set_addr(input int i, input logic [21:0] a);
    slot_addr[i*22 +: 22] = a;
  endtask

  function automatic logic [31:0] dw(input int i);
    return slot_dout[i*32 +: 32];
  endfunction

  // Act as the SDRAM controller for one transaction
  task automatic serve(input logic [31:0] d, input int ack_wait, input int data_wait);
    int n = 0;
    while (!sdram_req && n < 50) begin tick(); n++; end
    if (n == 50) check("req_timeout", 64'(sdram_req), 64'd1);
    repeat (ack_wait) tick();
    sdram_ack = 1'b1;
    if (data_wait == 0) begin data_rdy = 1'b1; data_read = d; end
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    if (data_wait > 0) begin
      repeat (data_wait - 1) tick();
      data_rdy = 1'b1; data_read = d;
      tick();
      data_rdy = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_ok", 64'(slot_ok), 64'd0);
    check("rst_dout", 64'(slot_dout[63:0]), 64'd0);
    check("rst_req", 64'(sdram_req), 64'd0);
    check("rst_refresh", 64'(refresh_en), 64'd0);
    rstn = 1'b1;
    tick(); tick();
    check("idle_refresh", 64'(refresh_en), 64'd1);

    // All five slots miss at once: grant order 0..4 from reset pointer
    set_addr(0, 22'h100); set_addr(1, 22'h200); set_addr(2, 22'h300);
    set_addr(3, 22'h400); set_addr(4, 22'h500);
    exp_q.push_back(22'h00100); exp_q.push_back(22'h14200); exp_q.push_back(22'h1C300);
    exp_q.push_back(22'h18400); exp_q.push_back(22'h20500);
    slot_cs = 5'h1F;
    for (int i = 0; i < 5; i++) serve(32'hA000_0000 + 32'(i), 1, 1);
    check("all_ok", 64'(slot_ok), 64'h1F);
    check("dout2", 64'(dw(2)), 64'hA000_0002);
    check("dout4", 64'(dw(4)), 64'hA000_0004);

    // Slot 0 re-misses after slot 2 is served: 3 and 4 come before it
    set_addr(0, 22'h101); set_addr(1, 22'h201); set_addr(2, 22'h301);
    set_addr(3, 22'h401); set_addr(4, 22'h501);
    exp_q.push_back(22'h00101); exp_q.push_back(22'h14201); exp_q.push_back(22'h1C301);
    repeat (3) serve(32'hB000_0000, 1, 1);
    set_addr(0, 22'h102);
    exp_q.push_back(22'h18401); exp_q.push_back(22'h20501); exp_q.push_back(22'h00102);
    repeat (3) serve(32'hB000_0001, 1, 1);
    check("rr_ok", 64'(slot_ok), 64'h1F);

    // Slot 0 basic fill and latency
    slot_cs = 5'h00; tick();
    set_addr(0, 22'h00010);
    exp_q.push_back(22'h00010);
    slot_cs = 5'h01;
    tick();
    check("req_1cyc", 64'(sdram_req), 64'd1);
    serve(32'hDEAD_BEEF, 1, 2);
    check("s0_ok", 64'(slot_ok[0]), 64'd1);
    check("s0_dout", 64'(dw(0)), 64'hDEAD_BEEF);
    check("s0_req_low", 64'(sdram_req), 64'd0);
    tick();
    check("s0_refresh", 64'(refresh_en), 64'd1);

    // Slot 1 with offset; address toggle drops ok at once and refetches
    set_addr(1, 22'h00020);
    exp_q.push_back(22'h14020);
    slot_cs = 5'h03;
    serve(32'hCAFE_0001, 1, 2);
    check("s1_ok", 64'(slot_ok), 64'h03);
    check("s1_dout", 64'(dw(1)), 64'hCAFE_0001);
    set_addr(1, 22'h00021);
    exp_q.push_back(22'h14021);
    #1 check("s1_toggle_ok", 64'(slot_ok[1]), 64'd0);
    serve(32'h1111_1111, 0, 1);
    check("s1_refill", 64'(dw(1)), 64'h1111_1111);
    check("s0_untouched", 64'(dw(0)), 64'hDEAD_BEEF);

    // Slot 4 address changes during WAIT_DATA; full address wraps mod 2^22
    slot_cs = 5'h00; tick();
    set_addr(4, 22'h3FFFF0);
    exp_q.push_back(22'h01FFF0);
    slot_cs = 5'h10;
    tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    set_addr(4, 22'h3FFFF1);
    exp_q.push_back(22'h01FFF1);
    data_rdy = 1'b1; data_read = 32'hBBBB_0004; tick(); data_rdy = 1'b0;
    check("s4_stale_ok", 64'(slot_ok[4]), 64'd0);
    check("s4_stale_dout", 64'(dw(4)), 64'hBBBB_0004);
    serve(32'hBBBB_0005, 1, 1);
    check("s4_refetch_ok", 64'(slot_ok[4]), 64'd1);

    // downloading during WAIT_ACK: transaction drains, data discarded
    slot_cs = 5'h01; tick();
    check("pre_dl_ok0", 64'(slot_ok), 64'h01);
    set_addr(1, 22'h700);
    exp_q.push_back(22'h14700);
    slot_cs = 5'h03;
    tick();
    downloading = 1'b1;
    tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    tick();
    data_rdy = 1'b1; data_read = 32'h0000_0055; tick(); data_rdy = 1'b0;
    check("dl_ok", 64'(slot_ok), 64'h00);
    repeat (4) tick();
    check("dl_no_req", 64'(sdram_req), 64'd0);
    check("dl_refresh", 64'(refresh_en), 64'd1);
    downloading = 1'b0;

    // ptr is 2 after slot 1: slot 0 first, then slot 1; ack+data same cycle
    exp_q.push_back(22'h00010); exp_q.push_back(22'h14700);
    serve(32'h2222_0000, 0, 0);
    check("same_cyc_ok0", 64'(slot_ok[0]), 64'd1);
    serve(32'h2222_0001, 1, 1);
    check("post_dl_ok", 64'(slot_ok), 64'h03);
    check("discarded", 64'(dw(1)), 64'h2222_0001);

    // loop_rst flushes caches
    loop_rst = 1'b1; tick(); loop_rst = 1'b0;
    check("loop_rst_ok", 64'(slot_ok), 64'h00);
    exp_q.push_back(22'h00010); exp_q.push_back(22'h14700);
    repeat (2) serve(32'h3333_0000, 1, 1);
    check("post_loop_ok", 64'(slot_ok), 64'h03);

    // Asynchronous reset in WAIT_DATA
    set_addr(0, 22'h900);
    exp_q.push_back(22'h00900);
    tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("arst_ok", 64'(slot_ok), 64'h00);
    check("arst_req", 64'(sdram_req), 64'd0);
    check("arst_dout", 64'(slot_dout[63:0]), 64'd0);
    check("arst_addr", 64'(sdram_addr), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_c + mon_pass, total_c + mon_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
